// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, FSM encoding and width helper for the 7-segment scan driver
package seg7_pkg;

    localparam int SEG_W = 7;

    // Segment codes {g,f,e,d,c,b,a}; entry [n] is the glyph for hex digit n
    localparam logic [15:0][SEG_W-1:0] HEX_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Bits needed to hold 0..v-1, never less than one bit
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to segment lookup
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    assign seg = HEX_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed 7-segment bank driver; SEG7_LZ_BLANK_EN enables leading-zero suppression
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NDIG      = 4,
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] value,
    output logic [NDIG-1:0]   digit_sel,
    output logic [6:0]        seg,
    output logic              frame_tick
);

    localparam int CNT_W = clog2(SCAN_DIV);
    localparam int IDX_W = clog2(NDIG);

    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    state_t            state_q, state_d;
    logic [4*NDIG-1:0] value_q, value_d;
    logic              first_q, first_d;
    logic [NDIG-1:0]   digit_sel_q, digit_sel_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              frame_tick_q, frame_tick_d;

    logic              wrap;
    logic              latch;
    logic              lead_zero;
    logic              show;
    logic [3:0]        nibble;
    logic [SEG_W-1:0]  seg_dec;

    seg7_hex_decode u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Slot timing, digit index, frame latch and FSM next-state
    always_comb begin
        wrap       = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));
        slot_cnt_d = wrap ? '0 : slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
        // A frame starts when the scan returns to digit 0; the very first wrap also latches
        // so a fresh value appears without waiting a whole frame after reset.
        latch        = wrap && ((idx_q == IDX_W'(NDIG - 1)) || first_q);
        first_d      = first_q && !wrap;
        value_d      = latch ? value : value_q;
        frame_tick_d = latch;
        state_d      = state_q;
        if (state_q == ST_BLANK) begin
            if (slot_cnt_q == CNT_W'(BLANK_CYC - 1)) begin
                state_d = ST_SHOW;
            end
        end else begin
            if (wrap) begin
                state_d = ST_BLANK;
            end
        end
    end

    // Output values for the next cycle, so selects and segments flip on the same edge as the state
    always_comb begin
        nibble = 4'(value_d >> (4 * idx_d));
`ifdef SEG7_LZ_BLANK_EN
        lead_zero = (idx_d != '0) && ((value_d >> (4 * idx_d)) == '0);
`else
        lead_zero = 1'b0;
`endif
        show        = (state_d == ST_SHOW) && !lead_zero;
        digit_sel_d = show ? (NDIG'(1) << idx_d) : '0;
        seg_d       = show ? seg_dec : '0;
    end

    // All state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q   <= '0;
            idx_q        <= '0;
            state_q      <= ST_BLANK;
            value_q      <= '0;
            first_q      <= 1'b1;
            digit_sel_q  <= '0;
            seg_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            value_q      <= value_d;
            first_q      <= first_d;
            digit_sel_q  <= digit_sel_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign digit_sel  = digit_sel_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule
